rm13_fht_decoder_pipe: RTL and testbench

//  Streaming soft-decision ML decoder for the (8,4) RM(1,3) / extended Hamming code.

---
 rtl/rm13_pkg.sv | 27 ++
 rtl/rm13_fht_decoder_pipe_fht_stage.sv | 48 ++++
 rtl/rm13_fht_decoder_pipe.sv | 131 +++++++++++++
 tb/tb_rm13_fht_decoder_pipe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rm13_pkg.sv
// Shared constants, message type and encoder for the (8,4) RM(1,3) code.
// The encoder is used by verification models; the decoder itself only needs the constants.
package rm13_pkg;

    localparam int N     = 8;
    localparam int K     = 4;
    localparam int LOG2N = 3;

    // Decoded message: bit 0 is m0, bits 3:1 are k = {m3,m2,m1}
    typedef struct packed {
        logic [LOG2N-1:0] k;
        logic             m0;
    } rm13_msg_t;

    // c_i = m0 ^ (m1 & i[0]) ^ (m2 & i[1]) ^ (m3 & i[2])
    function automatic logic [N-1:0] rm13_encode(input logic [K-1:0] msg);
        logic [N-1:0]     cw;
        logic [LOG2N-1:0] idx;
        cw = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            idx   = LOG2N'(i);
            cw[i] = msg[0] ^ (msg[1] & idx[0]) ^ (msg[2] & idx[1]) ^ (msg[3] & idx[2]);
        end
        return cw;
    endfunction

endpackage

// File: rtl/rm13_fht_decoder_pipe_fht_stage.sv
// One registered layer of the fast Hadamard transform.
// Pairs (j, j+SPAN) with bit SPAN of j clear produce (a+b, a-b); each output grows by one bit.
module fht_stage
    import rm13_pkg::*;
#(
    parameter int DW   = 7,
    parameter int SPAN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                in_valid,
    input  logic [N*(DW-1)-1:0] in_data,
    output logic                out_valid,
    output logic [N*DW-1:0]     out_data
);

    localparam int IW = DW - 1;

    logic [N*DW-1:0] bfly_s;

    for (genvar j = 0; j < N; j++) begin : g_bfly
        if ((j & SPAN) == 32'sd0) begin : g_pair
            logic [IW-1:0] a_s;
            logic [IW-1:0] b_s;
            logic [DW-1:0] ax_s;
            logic [DW-1:0] bx_s;
            assign a_s  = in_data[j*IW +: IW];
            assign b_s  = in_data[(j+SPAN)*IW +: IW];
            assign ax_s = {a_s[IW-1], a_s};
            assign bx_s = {b_s[IW-1], b_s};
            assign bfly_s[j*DW +: DW]        = ax_s + bx_s;
            assign bfly_s[(j+SPAN)*DW +: DW] = ax_s - bx_s;
        end
    end

    // Stage register: advances data and valid together unless the pipe is frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= {(N*DW){1'b0}};
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= bfly_s;
        end
    end

endmodule

// File: rtl/rm13_fht_decoder_pipe.sv
// Streaming soft-decision ML decoder for the (8,4) RM(1,3) code.
// Three FHT layers compute all eight correlations H(k) at full precision, then the
// largest |H(k)| (lowest k on ties) selects k and the sign of H(k*) gives m0.
// A single stall signal freezes the whole pipe, bubbles included.
module rm13_fht_decoder_pipe
    import rm13_pkg::*;
#(
    parameter int  W  = 6,
    localparam int MW = W + 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] r,
    input  logic [N-1:0]   erase,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [K-1:0]   m,
    output logic [MW-1:0]  metric
);

    logic                 stall_s;
    logic [N*W-1:0]       masked_s;
    logic                 s1_valid_s;
    logic                 s2_valid_s;
    logic                 s3_valid_s;
    logic [N*(W+1)-1:0]   s1_data_s;
    logic [N*(W+2)-1:0]   s2_data_s;
    logic [N*MW-1:0]      s3_data_s;
    logic [MW-1:0]        mag_s [N];
    logic [N-1:0]         neg_s;
    logic [LOG2N-1:0]     l1_idx_s [4];
    logic [MW-1:0]        l1_mag_s [4];
    logic [LOG2N-1:0]     l2_idx_s [2];
    logic [MW-1:0]        l2_mag_s [2];
    logic [LOG2N-1:0]     best_idx_s;
    logic [MW-1:0]        best_mag_s;
    rm13_msg_t            best_msg_s;

    // A held result blocks everything behind it; in_ready looks only at the output side
    assign stall_s  = out_valid && !out_ready;
    assign in_ready = !stall_s;

    // Erased samples contribute nothing to any correlation
    for (genvar i = 0; i < N; i++) begin : g_mask
        assign masked_s[i*W +: W] = erase[i] ? {W{1'b0}} : r[i*W +: W];
    end

    fht_stage #(.DW(W + 1), .SPAN(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .en(!stall_s),
        .in_valid(in_valid), .in_data(masked_s),
        .out_valid(s1_valid_s), .out_data(s1_data_s)
    );

    fht_stage #(.DW(W + 2), .SPAN(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .en(!stall_s),
        .in_valid(s1_valid_s), .in_data(s1_data_s),
        .out_valid(s2_valid_s), .out_data(s2_data_s)
    );

    fht_stage #(.DW(MW), .SPAN(4)) u_s3 (
        .clk(clk), .rst_n(rst_n), .en(!stall_s),
        .in_valid(s2_valid_s), .in_data(s2_data_s),
        .out_valid(s3_valid_s), .out_data(s3_data_s)
    );

    // Split each correlation into sign and magnitude; |-2^(W+2)| still fits unsigned MW
    always_comb begin
        neg_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            neg_s[i] = s3_data_s[i*MW + MW - 1];
            if (neg_s[i]) begin
                mag_s[i] = {MW{1'b0}} - s3_data_s[i*MW +: MW];
            end else begin
                mag_s[i] = s3_data_s[i*MW +: MW];
            end
        end
    end

    // Three-level argmax tree; the right branch wins only when strictly larger
    always_comb begin
        l1_idx_s = '{default: {LOG2N{1'b0}}};
        l1_mag_s = '{default: {MW{1'b0}}};
        l2_idx_s = '{default: {LOG2N{1'b0}}};
        l2_mag_s = '{default: {MW{1'b0}}};
        for (int p = 0; p < 4; p++) begin
            if (mag_s[2*p+1] > mag_s[2*p]) begin
                l1_idx_s[p] = LOG2N'(2*p + 1);
                l1_mag_s[p] = mag_s[2*p+1];
            end else begin
                l1_idx_s[p] = LOG2N'(2*p);
                l1_mag_s[p] = mag_s[2*p];
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (l1_mag_s[2*p+1] > l1_mag_s[2*p]) begin
                l2_idx_s[p] = l1_idx_s[2*p+1];
                l2_mag_s[p] = l1_mag_s[2*p+1];
            end else begin
                l2_idx_s[p] = l1_idx_s[2*p];
                l2_mag_s[p] = l1_mag_s[2*p];
            end
        end
        if (l2_mag_s[1] > l2_mag_s[0]) begin
            best_idx_s = l2_idx_s[1];
            best_mag_s = l2_mag_s[1];
        end else begin
            best_idx_s = l2_idx_s[0];
            best_mag_s = l2_mag_s[0];
        end
        best_msg_s.k  = best_idx_s;
        best_msg_s.m0 = neg_s[best_idx_s];
    end

    // Output register; holds while the sink is not ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            m         <= {K{1'b0}};
            metric    <= {MW{1'b0}};
        end else if (!stall_s) begin
            out_valid <= s3_valid_s;
            if (s3_valid_s) begin
                m      <= best_msg_s;
                metric <= best_mag_s;
            end
        end
    end

endmodule

// File: tb/tb_rm13_fht_decoder_pipe.sv
// Directed and streaming bench for rm13_fht_decoder_pipe at W=6.
module tb_rm13_fht_decoder_pipe;
    import rm13_pkg::*;

    localparam int W  = 6;
    localparam int MW = W + 3;
    localparam int NS = 10000;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [8*W-1:0] r;
    logic [7:0]     erase;
    logic           out_valid;
    logic           out_ready;
    logic [3:0]     m;
    logic [MW-1:0]  metric;

    int checks = 0;
    int errors = 0;

    rm13_fht_decoder_pipe #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .r(r), .erase(erase),
        .out_valid(out_valid), .out_ready(out_ready),
        .m(m), .metric(metric)
    );

    always #5 clk = ~clk;

    function automatic logic [8*W-1:0] fill(input int v);
        logic [8*W-1:0] o;
        for (int i = 0; i < 8; i++) o[i*W +: W] = W'(v);
        return o;
    endfunction

    function automatic logic [8*W-1:0] cw_vec(input logic [3:0] msg, input int amp);
        logic [8*W-1:0] o;
        logic [7:0]     cw;
        cw = rm13_encode(msg);
        for (int i = 0; i < 8; i++) o[i*W +: W] = cw[i] ? W'(-amp) : W'(amp);
        return o;
    endfunction

    // Brute-force correlation against all 16 codewords; first maximum wins
    function automatic void model(input logic [8*W-1:0] rv, input logic [7:0] ev,
                                  output logic [3:0] bm, output logic [MW-1:0] bmt);
        logic [7:0] cw;
        int best;
        int corr;
        int s;
        best = 0;
        bm   = 4'd0;
        for (int mm = 0; mm < 16; mm++) begin
            cw   = rm13_encode(4'(mm));
            corr = 0;
            for (int i = 0; i < 8; i++) begin
                s = ev[i] ? 0 : $signed(rv[i*W +: W]);
                corr += cw[i] ? -s : s;
            end
            if (mm == 0 || corr > best) begin
                best = corr;
                bm   = 4'(mm);
            end
        end
        bmt = MW'(best);
    endfunction

    // Drive one vector into an idle pipe and wait (bounded) for its result
    task automatic run_one(input logic [8*W-1:0] rv, input logic [7:0] ev,
                           output logic [3:0] gm, output logic [MW-1:0] gmt, output int lat);
        out_ready = 1'b1;
        r         = rv;
        erase     = ev;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        gm  = m;
        gmt = metric;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; r = '0; erase = 8'h00;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (m !== 4'd0) begin errors++; $display("FAIL rst_m got %h want 0", m); end
        checks++; if (metric !== 9'd0) begin errors++; $display("FAIL rst_metric got %0d want 0", metric); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        logic [3:0] gm; logic [MW-1:0] gmt; int lat;
        run_one(fill(31), 8'h00, gm, gmt, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL t1_latency got %0d want 4", lat); end
        checks++; if (gm !== 4'b0000) begin errors++; $display("FAIL t1_m got %b want 0000", gm); end
        checks++; if (gmt !== 9'd248) begin errors++; $display("FAIL t1_metric got %0d want 248", gmt); end
    endtask

    task automatic test_directed();
        logic [3:0] gm; logic [MW-1:0] gmt; int lat;
        logic signed [W-1:0] t2 [8];
        logic [8*W-1:0] rv;
        t2 = '{-6'sd20, 6'sd20, -6'sd20, 6'sd20, 6'sd20, -6'sd20, 6'sd20, -6'sd20};
        for (int i = 0; i < 8; i++) rv[i*W +: W] = t2[i];
        // Codeword of m=1011 at amplitude 20: H(5) = -160
        run_one(rv, 8'h00, gm, gmt, lat);
        checks++; if (gm !== 4'b1011) begin errors++; $display("FAIL t2_m got %b want 1011", gm); end
        checks++; if (gmt !== 9'd160) begin errors++; $display("FAIL t2_metric got %0d want 160", gmt); end
        // r[0] erased: seven matching samples, H(5) = -140
        run_one(rv, 8'h01, gm, gmt, lat);
        checks++; if (gm !== 4'b1011) begin errors++; $display("FAIL t2_erase_m got %b want 1011", gm); end
        checks++; if (gmt !== 9'd140) begin errors++; $display("FAIL t2_erase_metric got %0d want 140", gmt); end
        // Also r[1] = -20: sample 1 now opposes, H(5) = -120 + 20 = -100, others |H| <= 60
        rv[1*W +: W] = -6'sd20;
        run_one(rv, 8'h01, gm, gmt, lat);
        checks++; if (gm !== 4'b1011) begin errors++; $display("FAIL t2_flip_m got %b want 1011", gm); end
        checks++; if (gmt !== 9'd100) begin errors++; $display("FAIL t2_flip_metric got %0d want 100", gmt); end
        // All zero: every H is 0, lowest k and m0=0
        run_one(fill(0), 8'h00, gm, gmt, lat);
        checks++; if (gm !== 4'b0000) begin errors++; $display("FAIL t3_zero_m got %b want 0000", gm); end
        checks++; if (gmt !== 9'd0) begin errors++; $display("FAIL t3_zero_metric got %0d want 0", gmt); end
        // Fully erased nonzero input must behave as all zero
        run_one(fill(-17), 8'hFF, gm, gmt, lat);
        checks++; if (gm !== 4'b0000) begin errors++; $display("FAIL t3_erased_m got %b want 0000", gm); end
        checks++; if (gmt !== 9'd0) begin errors++; $display("FAIL t3_erased_metric got %0d want 0", gmt); end
        // Most negative everywhere: H(0) = -256
        run_one(fill(-32), 8'h00, gm, gmt, lat);
        checks++; if (gm !== 4'b0001) begin errors++; $display("FAIL t4_m got %b want 0001", gm); end
        checks++; if (gmt !== 9'd256) begin errors++; $display("FAIL t4_metric got %0d want 256", gmt); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL t4_latency got %0d want 4", lat); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] msgs [6];
        int sent, recv, cyc;
        logic acc, prev_stall;
        logic [3:0] pm; logic [MW-1:0] pmt;
        for (int i = 0; i < 6; i++) msgs[i] = 4'($urandom_range(0, 15));
        sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0; pm = 4'd0; pmt = '0;
        out_ready = 1'b1; erase = 8'h00; r = cw_vec(msgs[0], 31); in_valid = 1'b1;
        while (recv < 6 && cyc < 40) begin
            @(negedge clk);
            checks++;
            if (in_ready !== out_ready) begin errors++; $display("FAIL t5_in_ready cyc %0d got %b want %b", cyc, in_ready, out_ready); end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || m !== pm || metric !== pmt) begin
                    errors++; $display("FAIL t5_hold cyc %0d got %b/%h/%0d want 1/%h/%0d", cyc, out_valid, m, metric, pm, pmt);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (m !== msgs[recv] || metric !== 9'd248) begin
                    errors++; $display("FAIL t5_result idx %0d got %h/%0d want %h/248", recv, m, metric, msgs[recv]);
                end
                recv++;
            end
            acc        = in_valid && in_ready;
            prev_stall = out_valid && !out_ready;
            pm = m; pmt = metric;
            @(posedge clk); #1;
            cyc++;
            if (acc) sent++;
            if (sent < 6) r = cw_vec(msgs[sent], 31);
            else in_valid = 1'b0;
            out_ready = !(cyc >= 4 && cyc <= 6);
        end
        checks++; if (recv !== 6) begin errors++; $display("FAIL t5_count got %0d want 6", recv); end
        out_ready = 1'b1; in_valid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        logic [3:0] gm; logic [MW-1:0] gmt; int lat;
        logic [3:0] msgs [5];
        msgs = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB};
        out_ready = 1'b0; erase = 8'h00;
        // Four accepted, then the full output stalls the fifth
        for (int i = 0; i < 5; i++) begin
            r = cw_vec(msgs[i], 31); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || m !== 4'hF) begin errors++; $display("FAIL t6_pre got %b/%h want 1/f", out_valid, m); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t6_async_valid got %b want 0", out_valid); end
        checks++; if (m !== 4'd0 || metric !== 9'd0) begin errors++; $display("FAIL t6_async_data got %h/%0d want 0/0", m, metric); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t6_async_ready got %b want 1", in_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t6_ghost cyc %0d got %b want 0", c, out_valid); end
        end
        @(posedge clk); #1;
        run_one(cw_vec(4'h6, 25), 8'h00, gm, gmt, lat);
        checks++; if (gm !== 4'h6 || gmt !== 9'd200) begin errors++; $display("FAIL t6_after got %h/%0d want 6/200", gm, gmt); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL t6_latency got %0d want 4", lat); end
    endtask

    task automatic test_soak();
        logic [3+MW:0] q [$];
        logic [3+MW:0] e;
        logic [3:0] em; logic [MW-1:0] emt;
        int sent, recv, cyc;
        logic acc;
        sent = 0; recv = 0; cyc = 0; in_valid = 1'b0; out_ready = 1'b1;
        while (recv < NS && cyc < 60000) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL soak_extra got %h/%0d with nothing pending", m, metric);
                end else begin
                    e = q.pop_front();
                    if ({m, metric} !== e) begin
                        errors++; $display("FAIL soak_result idx %0d got %h/%0d want %h/%0d", recv, m, metric, e[3+MW:MW], e[MW-1:0]);
                    end
                end
                recv++;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                model(r, erase, em, emt);
                q.push_back({em, emt});
                sent++;
            end
            if (!in_valid || acc) begin
                in_valid = (sent < NS) && ($urandom_range(0, 4) != 0);
                for (int i = 0; i < 8; i++) begin
                    r[i*W +: W] = W'($urandom_range(0, 63));
                    erase[i]    = ($urandom_range(0, 3) == 0);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        checks++; if (recv !== NS) begin errors++; $display("FAIL soak_count got %0d want %0d", recv, NS); end
        in_valid = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
        test_soak();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
